// File: rtl/dp_tap_ctrl.sv
// IEEE 1149.1 TAP controller oversampled in the iclk domain; drives the boundary-scan
// chain controls and muxes IR/IDCODE/BYPASS/boundary data onto tdo.
`timescale 1ns/1ps
module dp_tap_ctrl #(
   parameter int unsigned          IR_WIDTH   = 4,
   parameter logic [IR_WIDTH-1:0]  EXTEST     = IR_WIDTH'(0),
   parameter logic [IR_WIDTH-1:0]  SAMPLE     = IR_WIDTH'(1),
   parameter logic [IR_WIDTH-1:0]  IDCODE     = IR_WIDTH'(2),
   parameter logic [31:0]          IDCODE_VAL = 32'h1000_0001
) (
   input  logic       iclk,
   input  logic       ireset,
   input  logic       tck,
   input  logic       tms,
   input  logic       tdi,
   output logic       tdo,
   output logic       tdo_en,
   input  logic       bsc_sdo,
   output logic       bsc_sdi,
   output logic       mode,
   output logic       shift_dr,
   output logic       clk_dr,
   output logic       update_dr,
   output logic [3:0] tap_state
);

   typedef enum logic [3:0] {
      TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
      SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
      UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
      EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
   } tap_state_t;

   tap_state_t          state, state_d;
   logic                tck_s1, tck_s2, tck_s3;
   logic                tms_s1, tms_s2;
   logic                tdi_s1, tdi_s2;
   logic                tck_rise_q, tck_fall_q;
   logic                rise_c, fall_c;
   logic [IR_WIDTH-1:0] ir, ir_sh, ir_d;
   logic [31:0]         idcode_sh;
   logic                byp;
   logic                bnd_sel;

   // rise_c/fall_c are seen one cycle before tck_rise_q/tck_fall_q, so the chain
   // pulses are issued while the FSM still holds the state they belong to
   assign rise_c    = tck_s2 & ~tck_s3;
   assign fall_c    = ~tck_s2 & tck_s3;
   assign bnd_sel   = (ir == EXTEST) | (ir == SAMPLE);
   assign shift_dr  = bnd_sel & (state == SH_DR);
   assign bsc_sdi   = tdi_s2;
   assign tap_state = 4'(state);

   always_ff @(posedge iclk) begin
      if (ireset) state <= TLR;
      else        state <= state_d;
   end

   // next-state: standard 1149.1 graph, stepping only on the synced tck rise
   always_comb begin
      state_d = state;
      if (tck_rise_q) begin
         unique case (state)
            TLR:    state_d = tms_s2 ? TLR    : RTI;
            RTI:    state_d = tms_s2 ? SEL_DR : RTI;
            SEL_DR: state_d = tms_s2 ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms_s2 ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms_s2 ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms_s2 ? UPD_DR : PA_DR;
            PA_DR:  state_d = tms_s2 ? EX2_DR : PA_DR;
            EX2_DR: state_d = tms_s2 ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms_s2 ? SEL_DR : RTI;
            SEL_IR: state_d = tms_s2 ? TLR    : CAP_IR;
            CAP_IR: state_d = tms_s2 ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms_s2 ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms_s2 ? UPD_IR : PA_IR;
            PA_IR:  state_d = tms_s2 ? EX2_IR : PA_IR;
            EX2_IR: state_d = tms_s2 ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms_s2 ? SEL_DR : RTI;
            default: state_d = TLR;
         endcase
      end
   end

   always_comb begin
      ir_d = ir;
      if (state == TLR)                    ir_d = IDCODE;
      else if (tck_fall_q && state == UPD_IR) ir_d = ir_sh;
   end

   always_ff @(posedge iclk) begin
      if (ireset) begin
         tck_s1     <= 1'b0;
         tck_s2     <= 1'b0;
         tck_s3     <= 1'b0;
         tms_s1     <= 1'b0;
         tms_s2     <= 1'b0;
         tdi_s1     <= 1'b0;
         tdi_s2     <= 1'b0;
         tck_rise_q <= 1'b0;
         tck_fall_q <= 1'b0;
         clk_dr     <= 1'b0;
         update_dr  <= 1'b0;
         ir         <= IDCODE;
         ir_sh      <= '0;
         idcode_sh  <= '0;
         byp        <= 1'b0;
         mode       <= 1'b0;
         tdo        <= 1'b0;
         tdo_en     <= 1'b0;
      end else begin
         tck_s1     <= tck;
         tck_s2     <= tck_s1;
         tck_s3     <= tck_s2;
         tms_s1     <= tms;
         tms_s2     <= tms_s1;
         tdi_s1     <= tdi;
         tdi_s2     <= tdi_s1;
         tck_rise_q <= rise_c;
         tck_fall_q <= fall_c;
         clk_dr     <= rise_c & bnd_sel & ((state == CAP_DR) | (state == SH_DR));
         update_dr  <= fall_c & bnd_sel & (state == UPD_DR);
         ir         <= ir_d;
         mode       <= (ir_d == EXTEST);

         if (tck_rise_q) begin
            unique case (state)
               CAP_IR: ir_sh <= IR_WIDTH'(1);
               SH_IR:  ir_sh <= {tdi_s2, ir_sh[IR_WIDTH-1:1]};
               CAP_DR: begin
                  idcode_sh <= IDCODE_VAL;
                  byp       <= 1'b0;
               end
               SH_DR: begin
                  idcode_sh <= {tdi_s2, idcode_sh[31:1]};
                  byp       <= tdi_s2;
               end
               default: ;
            endcase
         end

         // tdo launches on the falling tck so the host samples it on the next rise
         if (tck_fall_q) begin
            unique case (state)
               SH_IR: begin
                  tdo    <= ir_sh[0];
                  tdo_en <= 1'b1;
               end
               SH_DR: begin
                  tdo    <= bnd_sel ? bsc_sdo : ((ir == IDCODE) ? idcode_sh[0] : byp);
                  tdo_en <= 1'b1;
               end
               default: begin
                  tdo    <= 1'b0;
                  tdo_en <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Randomized scoreboard bench for dp_tap_ctrl: scan tasks push expected tdo bits and
// chain pulses computed from shift-register queue models; monitors pop and compare.
`timescale 1ns/1ps
module tb_dp_tap_ctrl;

   localparam int unsigned IRW = 4;
   localparam logic [31:0] IDV = 32'h1000_0001;

   logic       iclk = 1'b0;
   logic       ireset, tck, tms, tdi, bsc_sdo;
   logic       tdo, tdo_en, bsc_sdi, mode, shift_dr, clk_dr, update_dr;
   logic [3:0] tap_state;

   int checks = 0;
   int errors = 0;
   bit tdo_q[$];
   bit clk_q[$];
   bit upd_q[$];
   logic [3:0] cur_ir;

   dp_tap_ctrl dut (
      .iclk(iclk), .ireset(ireset), .tck(tck), .tms(tms), .tdi(tdi),
      .tdo(tdo), .tdo_en(tdo_en), .bsc_sdo(bsc_sdo), .bsc_sdi(bsc_sdi),
      .mode(mode), .shift_dr(shift_dr), .clk_dr(clk_dr), .update_dr(update_dr),
      .tap_state(tap_state)
   );

   always #5 iclk = ~iclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // tdo is launched on tck fall, so it is stable at the following tck rise
   always @(posedge tck) begin
      if (tdo_en) begin
         if (tdo_q.size() == 0) chk("tdo_unexpected_en", 32'(tdo_en), 32'(0));
         else                   chk("tdo_bit", 32'(tdo), 32'(tdo_q.pop_front()));
      end else begin
         chk("tdo_idle_zero", 32'(tdo), 32'(0));
      end
   end

   always @(negedge iclk) begin
      if (clk_dr) begin
         if (clk_q.size() == 0) chk("clk_dr_unexpected", 32'(clk_dr), 32'(0));
         else                   chk("clk_dr_shift_dr", 32'(shift_dr), 32'(clk_q.pop_front()));
      end
      if (update_dr) begin
         if (upd_q.size() == 0) chk("update_dr_unexpected", 32'(update_dr), 32'(0));
         else                   chk("update_dr_pulse", 32'(update_dr), 32'(upd_q.pop_front()));
      end
   end

   // one tck period: inputs change mid-low, rise, then fall at the end
   task automatic tck_cycle(input bit tms_v, input bit tdi_v, output bit sdo_v);
      #60;
      tms     = tms_v;
      tdi     = tdi_v;
      sdo_v   = 1'($urandom_range(0, 1));
      bsc_sdo = sdo_v;
      #20 tck = 1'b1;
      #80 tck = 1'b0;
   endtask

   task automatic scan_ir(input int n, input logic [63:0] bits);
      bit q[$];
      bit s;
      logic [3:0] ir_new;
      for (int i = 0; i < int'(IRW); i++) q.push_back(i == 0);
      tck_cycle(1'b1, 1'b0, s);
      tck_cycle(1'b1, 1'b0, s);
      tck_cycle(1'b0, 1'b0, s);
      tck_cycle(1'b0, 1'b0, s);
      tdo_q.push_back(q[0]);
      for (int j = 0; j < n; j++) begin
         void'(q.pop_front());
         q.push_back(bits[j]);
         tck_cycle(j == n - 1, bits[j], s);
         if (j < n - 1) tdo_q.push_back(q[0]);
      end
      for (int i = 0; i < int'(IRW); i++) ir_new[i] = q[i];
      chk("mode_before_upd_ir", 32'(mode), 32'(cur_ir == 4'h0));
      tck_cycle(1'b1, 1'b0, s);
      tck_cycle(1'b0, 1'b0, s);
      cur_ir = ir_new;
      chk("mode_after_upd_ir", 32'(mode), 32'(cur_ir == 4'h0));
      chk("state_rti_after_ir", 32'(tap_state), 32'(1));
   endtask

   task automatic scan_dr(input int n, input logic [63:0] bits);
      bit q[$];
      bit s;
      bit bnd;
      bnd = (cur_ir == 4'h0) || (cur_ir == 4'h1);
      if (cur_ir == 4'h2) for (int i = 0; i < 32; i++) q.push_back(IDV[i]);
      else                q.push_back(1'b0);
      tck_cycle(1'b1, 1'b0, s);
      tck_cycle(1'b0, 1'b0, s);
      if (bnd) clk_q.push_back(1'b0);
      tck_cycle(1'b0, 1'b0, s);
      tdo_q.push_back(bnd ? s : q[0]);
      for (int j = 0; j < n; j++) begin
         if (bnd) clk_q.push_back(1'b1);
         void'(q.pop_front());
         q.push_back(bits[j]);
         tck_cycle(j == n - 1, bits[j], s);
         if (j < n - 1) tdo_q.push_back(bnd ? s : q[0]);
      end
      if (bnd) upd_q.push_back(1'b1);
      tck_cycle(1'b1, 1'b0, s);
      tck_cycle(1'b0, 1'b0, s);
      chk("state_rti_after_dr", 32'(tap_state), 32'(1));
      chk("mode_stable_dr", 32'(mode), 32'(cur_ir == 4'h0));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_tdo"}, 32'(tdo), 32'(0));
      chk({tag, "_tdo_en"}, 32'(tdo_en), 32'(0));
      chk({tag, "_mode"}, 32'(mode), 32'(0));
      chk({tag, "_shift_dr"}, 32'(shift_dr), 32'(0));
      chk({tag, "_clk_dr"}, 32'(clk_dr), 32'(0));
      chk({tag, "_update_dr"}, 32'(update_dr), 32'(0));
      chk({tag, "_tap_state"}, 32'(tap_state), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      bit s;
      logic [63:0] rb;
      ireset = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; bsc_sdo = 1'b0;
      cur_ir = 4'h2;
      repeat (4) @(negedge iclk);
      ireset = 1'b0;
      #2;
      check_all_zero("reset");

      // walk into SH_DR with IR=IDCODE, then escape with five tms=1
      tck_cycle(1'b0, 1'b0, s);
      tck_cycle(1'b1, 1'b0, s);
      tck_cycle(1'b0, 1'b0, s);
      tck_cycle(1'b0, 1'b0, s);
      tdo_q.push_back(IDV[0]);
      chk("state_sh_dr", 32'(tap_state), 32'(4));
      repeat (5) tck_cycle(1'b1, 1'b0, s);
      chk("state_tlr_after_5", 32'(tap_state), 32'(0));
      chk("mode_tlr", 32'(mode), 32'(0));
      tck_cycle(1'b0, 1'b0, s);
      chk("state_rti", 32'(tap_state), 32'(1));

      scan_ir(4, 64'h0);
      scan_dr(8, {$urandom, $urandom});
      scan_ir(4, 64'h1);
      scan_dr(8, {$urandom, $urandom});
      scan_ir(4, 64'h2);
      scan_dr(40, {$urandom, $urandom});
      scan_ir(4, 64'hF);
      scan_dr(8, 64'hA5);

      for (int r = 0; r < 8; r++) begin
         rb = {$urandom, $urandom};
         if (r < 4) scan_ir(4, 64'($urandom_range(0, 3)));
         else       scan_ir(int'($urandom_range(2, 8)), rb);
         scan_dr(int'($urandom_range(1, 40)), {$urandom, $urandom});
      end

      // reset in the middle of an EXTEST DR shift
      scan_ir(4, 64'h0);
      tck_cycle(1'b1, 1'b0, s);
      tck_cycle(1'b0, 1'b0, s);
      clk_q.push_back(1'b0);
      tck_cycle(1'b0, 1'b0, s);
      tdo_q.push_back(s);
      for (int j = 0; j < 3; j++) begin
         clk_q.push_back(1'b1);
         tck_cycle(1'b0, 1'($urandom_range(0, 1)), s);
         tdo_q.push_back(s);
      end
      #30;
      @(negedge iclk) ireset = 1'b1;
      @(negedge iclk);
      check_all_zero("midshift_reset");
      ireset = 1'b0;
      cur_ir = 4'h2;
      tdo_q.delete();
      #2;
      repeat (5) tck_cycle(1'b1, 1'b0, s);
      chk("state_tlr_post_reset", 32'(tap_state), 32'(0));
      chk("mode_post_reset", 32'(mode), 32'(0));
      tck_cycle(1'b0, 1'b0, s);
      scan_dr(32, {$urandom, $urandom});

      #400;
      chk("tdo_queue_drained", 32'(tdo_q.size()), 32'(0));
      chk("clk_dr_queue_drained", 32'(clk_q.size()), 32'(0));
      chk("update_dr_queue_drained", 32'(upd_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
